// File: rtl/cpu_mem_pkg.sv
// Shared memory-handshake definitions: responder FSM states, request op codes
// and default geometry, also used by the CPU control unit.
package cpu_mem_pkg;

    localparam int MEM_ADDR_W      = 9;
    localparam int MEM_DATA_W      = 32;
    localparam int MEM_WAIT_CYCLES = 2;
    localparam int MEM_CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } mem_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

    // WAIT exits when the counter reaches 0, so it is loaded with cycles-1.
    function automatic logic [MEM_CNT_W-1:0] wait_load(input int cycles);
        logic [MEM_CNT_W-1:0] v;
        v = '0;
        if (cycles > 0) v = MEM_CNT_W'(cycles - 1);
        return v;
    endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port RAM: synchronous write, registered read. Only the read register
// is reset; the array keeps its contents across rst.
module ram_sp #(
    parameter int    ADDR_W    = 9,
    parameter int    DATA_W    = 32,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // Read register only moves on a read, so it holds the last read value.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle MAR/MDR protocol: edge-detects
// requests, latches them, inserts wait states, accesses ram_sp, signals done.
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [MEM_CNT_W-1:0] CNT_LOAD = wait_load(WAIT_CYCLES);

    mem_state_e            state_d, state_q;
    logic [MEM_CNT_W-1:0]  cnt_d, cnt_q;
    logic [ADDR_W-1:0]     addr_d, addr_q;
    logic [DATA_W-1:0]     wdata_d, wdata_q;
    mem_op_e               op_d, op_q;
    logic                  busy_d, busy_q;
    logic                  done_d, done_q;
    logic                  err_d, err_q;
    logic                  read_prev_q, write_prev_q;
    logic                  read_rise, write_rise;
    logic                  ram_we, ram_re;

    assign read_rise  = read  & ~read_prev_q;
    assign write_rise = write & ~write_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A fresh edge with the other request also high is a conflict.
                if (read_rise || write_rise) begin
                    if (read && write) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = addr;
                        wdata_d = wdata;
                        op_d    = write ? OP_WRITE : OP_READ;
                        cnt_d   = CNT_LOAD;
                        state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_ACCESS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   if (!read && !write) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_WAIT) || (state_d == ST_ACCESS);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_q         <= OP_READ;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            read_prev_q  <= 1'b0;
            write_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_q         <= op_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            read_prev_q  <= read;
            write_prev_q <= write;
        end
    end

    // The RAM acts on the edge that leaves ACCESS.
    assign ram_we = (state_q == ST_ACCESS) && (op_q == OP_WRITE);
    assign ram_re = (state_q == ST_ACCESS) && (op_q == OP_READ);

    ram_sp #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .INIT_FILE ("")
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule
